// File: rtl/rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// rf_writeback_queue
//
// Write-side initiator for the 8x16 register file. Writeback results are
// buffered in an in-order FIFO and drained into the RF at most one write per
// cycle. Decode can read values that are still queued through a two-port
// bypass, so it never sees a stale RF value for a register with a pending
// write.
//
// Ports
//   clk       rising-edge clock
//   resetn    synchronous, active-low reset
//   in_valid  writeback request valid
//   in_ready  queue can accept this cycle (state only: !full)
//   in_addr   destination register of the request
//   in_data   result value of the request
//   rd_addr   decode read pair {A,B}, A in the upper ADDR_W bits
//   rd_hit    {hitA,hitB}: the newest value of that register is queued
//   rd_data   {bypassA,bypassB}; a half reads 0 when its hit bit is 0
//   rf_stall  hold RF writes (head is not popped)
//   rf_we     RF write enable; the RF loads rf_din at this clock edge
//   rf_waddr  RF write address (head entry, 0 when empty)
//   rf_din    RF write data (head entry, 0 when empty)
//   count     occupancy, 0..DEPTH
//   empty     count == 0
//   full      count == DEPTH
// -----------------------------------------------------------------------------
module rf_writeback_queue #(
   parameter int DEPTH  = 4,   // power of two, >= 2
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [2*ADDR_W-1:0]      rd_addr,
   output logic [1:0]               rd_hit,
   output logic [2*DATA_W-1:0]      rd_data,
   input  logic                     rf_stall,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_din,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg,  count_next;
   // One valid bit per slot: set on push, cleared on pop. Reset clears
   // these instead of touching the storage arrays.
   logic [DEPTH-1:0]  valid_reg,  valid_next;

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic push;
   logic pop;
   logic empty_int;
   logic full_int;

   // ------------------------------------------------------------------
   // Status and handshake
   // ------------------------------------------------------------------
   assign empty_int = (count_reg == '0);
   assign full_int  = (count_reg == CNT_W'(DEPTH));

   // in_ready looks at state only; a pop in the same cycle does not open
   // a slot for a push while full.
   assign in_ready = !full_int;
   assign push     = in_valid && !full_int;
   assign pop      = !empty_int && !rf_stall;

   assign count = count_reg;
   assign empty = empty_int;
   assign full  = full_int;

   // ------------------------------------------------------------------
   // RF write port: head entry, forced to zero while empty so the RF side
   // never sees stale slot contents.
   // ------------------------------------------------------------------
   assign rf_we    = pop;
   assign rf_waddr = empty_int ? '0 : addr_mem[rd_ptr_reg];
   assign rf_din   = empty_int ? '0 : data_mem[rd_ptr_reg];

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      valid_next  = valid_reg;

      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase

      // A push never lands on the slot being popped: push needs !full,
      // pop needs !empty, so wr_ptr != rd_ptr or the slot is free.
      if (pop) begin
         valid_next[rd_ptr_reg] = 1'b0;
      end
      if (push) begin
         valid_next[wr_ptr_reg] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Control registers (reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         valid_reg  <= valid_next;
      end
   end

   // ------------------------------------------------------------------
   // Entry storage (no reset; slot contents are qualified by valid_reg).
   // Writes are suppressed during reset so a request presented in the
   // reset cycle leaves no trace.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (resetn && push) begin
         addr_mem[wr_ptr_reg] <= in_addr;
         data_mem[wr_ptr_reg] <= in_data;
      end
   end

   // ------------------------------------------------------------------
   // Bypass: one search per read half. Entries are visited from oldest
   // (rd_ptr) to youngest, so a later match overrides an earlier one and
   // the youngest matching value wins. The head is still searched while it
   // is being written because the RF only updates at the edge. The
   // incoming in_* request is deliberately not searched.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      logic [ADDR_W-1:0] sel_addr;
      logic              hit;
      logic [DATA_W-1:0] hit_data;
      logic [PTR_W-1:0]  idx;

      assign sel_addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
         hit      = 1'b0;
         hit_data = '0;
         idx      = rd_ptr_reg;
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_reg + PTR_W'(i);
            if (valid_reg[idx] && (addr_mem[idx] == sel_addr)) begin
               hit      = 1'b1;
               hit_data = data_mem[idx];
            end
         end
      end

      assign rd_hit[gi]                    = hit;
      assign rd_data[gi*DATA_W +: DATA_W]  = hit_data;
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rf_writeback_queue.
// A negedge monitor keeps a scoreboard queue of accepted writebacks: entries
// are pushed when a request is accepted and popped/compared when the RF
// write is expected. The same queue drives the occupancy and bypass model.
// Directed sequences in the main initial block add point checks.
// -----------------------------------------------------------------------------
module tb_rf_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_t;

   logic                  clk;
   logic                  resetn;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_W-1:0]     in_addr;
   logic [DATA_W-1:0]     in_data;
   logic [2*ADDR_W-1:0]   rd_addr;
   logic [1:0]            rd_hit;
   logic [2*DATA_W-1:0]   rd_data;
   logic                  rf_stall;
   logic                  rf_we;
   logic [ADDR_W-1:0]     rf_waddr;
   logic [DATA_W-1:0]     rf_din;
   logic [CNT_W-1:0]      count;
   logic                  empty;
   logic                  full;

   int n_checks = 0;
   int n_fail   = 0;

   wb_t sb[$];

   rf_writeback_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .rd_addr  (rd_addr),
      .rd_hit   (rd_hit),
      .rd_data  (rd_data),
      .rf_stall (rf_stall),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_din   (rf_din),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      rf_stall = 1'b0;
      for (int i = 0; i < 20 && !empty; i++) step();
      #1;
      check("drain_empty", empty, 1'b1);
   endtask

   // Scoreboard / reference model, evaluated mid-cycle.
   always @(negedge clk) begin : mon
      logic              exp_pop;
      logic              can_push;
      logic [1:0]        exp_hit;
      logic [2*DATA_W-1:0] exp_data;
      wb_t               e;
      if (!resetn) begin
         sb.delete();
      end else begin
         exp_pop  = (sb.size() > 0) && !rf_stall;
         can_push = (sb.size() < DEPTH);
         check("count", count, sb.size());
         check("in_ready", in_ready, can_push);
         check("rf_we", rf_we, exp_pop);

         exp_hit  = '0;
         exp_data = '0;
         for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < sb.size(); k++) begin
               if (sb[k].addr == rd_addr[h*ADDR_W +: ADDR_W]) begin
                  exp_hit[h]                   = 1'b1;
                  exp_data[h*DATA_W +: DATA_W] = sb[k].data;
               end
            end
         end
         check("rd_hit", rd_hit, exp_hit);
         check("rd_data", rd_data, exp_data);

         if (exp_pop) begin
            e = sb.pop_front();
            $display("rf write r%0d <= %04h (expected r%0d <= %04h)", rf_waddr, rf_din, e.addr, e.data);
            check("rf_waddr", rf_waddr, e.addr);
            check("rf_din", rf_din, e.data);
         end
         if (in_valid && can_push) begin
            e.addr = in_addr;
            e.data = in_data;
            sb.push_back(e);
         end
      end
   end

   initial begin
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      rd_addr  = '0;
      rf_stall = 1'b0;

      // Reset held for two cycles
      step();
      step();
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_count", count, 0);
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_rd_hit", rd_hit, 2'b00);
      check("rst_rd_data", rd_data, 32'h0);
      resetn = 1'b1;

      // Single push, no stall: reaches the RF one edge later
      rd_addr = {3'd3, 3'd0};
      push_req(3'd3, 16'hABCD);
      #1;
      check("t2_rf_we", rf_we, 1'b1);
      check("t2_rf_waddr", rf_waddr, 3'd3);
      check("t2_rf_din", rf_din, 16'hABCD);
      check("t2_head_hit", rd_hit, 2'b10);
      check("t2_head_data", rd_data, 32'hABCD_0000);
      step();
      check("t2_empty", empty, 1'b1);
      check("t2_rf_we_off", rf_we, 1'b0);
      check("t2_waddr_zero", rf_waddr, 3'd0);
      check("t2_din_zero", rf_din, 16'h0);

      // Stall, fill, hold fifth request, release
      rf_stall = 1'b1;
      for (int i = 1; i <= 4; i++) push_req(ADDR_W'(i), DATA_W'(i));
      in_valid = 1'b1;
      in_addr  = 3'd5;
      in_data  = 16'h0005;
      #1;
      check("t3_full", full, 1'b1);
      check("t3_in_ready", in_ready, 1'b0);
      check("t3_count", count, 4);
      step();
      check("t3_held_count", count, 4);
      check("t3_stall_no_we", rf_we, 1'b0);
      check("t3_head_still", rf_waddr, 3'd1);
      rf_stall = 1'b0;
      #1;
      check("t3_release_we", rf_we, 1'b1);
      check("t3_release_addr", rf_waddr, 3'd1);
      check("t3_no_push_full", in_ready, 1'b0);
      step();
      check("t3_after_pop", count, 3);
      step();
      in_valid = 1'b0;
      check("t3_push_pop", count, 3);
      drain();

      // Bypass: youngest duplicate wins, per half
      rf_stall = 1'b1;
      push_req(3'd2, 16'h1111);
      push_req(3'd2, 16'h2222);
      rd_addr = {3'd2, 3'd5};
      #1;
      check("t4_hit_a", rd_hit, 2'b10);
      check("t4_data_a", rd_data, 32'h2222_0000);
      rd_addr = {3'd5, 3'd2};
      #1;
      check("t4_hit_b", rd_hit, 2'b01);
      check("t4_data_b", rd_data, 32'h0000_2222);
      push_req(3'd5, 16'h5555);
      #1;
      check("t4_hit_ab", rd_hit, 2'b11);
      check("t4_data_ab", rd_data, 32'h5555_2222);
      rf_stall = 1'b0;
      #1;
      check("t4_head_addr", rf_waddr, 3'd2);
      check("t4_head_din", rf_din, 16'h1111);
      check("t4_bypass_young", rd_data, 32'h5555_2222);
      drain();

      // Simultaneous push and pop at count 2
      rf_stall = 1'b1;
      push_req(3'd6, 16'h0006);
      push_req(3'd7, 16'h0007);
      rf_stall = 1'b0;
      in_valid = 1'b1;
      in_addr  = 3'd0;
      in_data  = 16'h00AA;
      step();
      in_valid = 1'b0;
      check("t5_count_same", count, 2);
      drain();

      // Pointer wrap: nine back-to-back entries
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_addr = ADDR_W'(i);
         in_data = DATA_W'(16'hC000 + i);
         step();
      end
      in_valid = 1'b0;
      drain();

      // Random traffic with random stalls and read addresses
      for (int i = 0; i < 80; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         rf_stall = ($urandom_range(0, 2) == 0);
         in_addr  = ADDR_W'($urandom_range(0, 7));
         in_data  = DATA_W'($urandom);
         rd_addr  = (2*ADDR_W)'($urandom_range(0, 63));
         step();
      end
      drain();

      // Reset with three writes queued
      rf_stall = 1'b1;
      push_req(3'd1, 16'h00A1);
      push_req(3'd2, 16'h00A2);
      push_req(3'd3, 16'h00A3);
      rd_addr = {3'd1, 3'd2};
      #1;
      check("t6_count3", count, 3);
      check("t6_hit_pre", rd_hit, 2'b11);
      resetn = 1'b0;
      step();
      resetn   = 1'b1;
      rf_stall = 1'b0;
      #1;
      check("t6_empty", empty, 1'b1);
      check("t6_rf_we", rf_we, 1'b0);
      check("t6_count0", count, 0);
      check("t6_rd_hit", rd_hit, 2'b00);
      check("t6_rd_data", rd_data, 32'h0);
      step();
      check("t6_rf_we_later", rf_we, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
